regfile_writeback_ctrl: RTL and testbench

REGFILE_WRITEBACK_CTRL -- requirements
Module: regfile_writeback_ctrl

---
 rtl/regfile_writeback_ctrl.sv | 168 ++++++++++++++++
 tb/tb_regfile_writeback_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_ctrl.sv
// regfile_writeback_ctrl
//   Arbitrates the register-file write port between a single-cycle ALU result
//   and a multi-cycle load result. Results that cannot be written this cycle
//   are held in a small in-order pending-write queue. The queue head has
//   priority over new results so that program order is preserved.
//
// Optional feature: define WB_FORWARD_EN to add fwd_1_data / fwd_2_data. These
//   carry the youngest queued value for reg_1 / reg_2, and are 0 when no queued
//   entry matches.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data         ALU result (dropped if presented while stall)
//   mem_valid/mem_rd/mem_data         load result, accepted when mem_ready
//   mem_ready                         queue can absorb a load result
//   reg_write/reg_write_data/
//   reg_write_control                 register-file write port
//   reg_1/reg_2, busy_1/busy_2        hazard query: queued write pending
//   stall                             queue full, core must hold alu_valid low
//   ovf                               sticky flag: an ALU write was dropped
//   fwd_1_data/fwd_2_data             (WB_FORWARD_EN only) forwarded queue data
module regfile_writeback_ctrl #(
  parameter int REG_ADDR = 5,
  parameter int REG_DATA = 32,
  parameter int WB_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  logic [REG_ADDR-1:0] alu_rd,
  input  logic [REG_DATA-1:0] alu_data,
  input  logic                mem_valid,
  input  logic [REG_ADDR-1:0] mem_rd,
  input  logic [REG_DATA-1:0] mem_data,
  output logic                mem_ready,
  output logic [REG_ADDR-1:0] reg_write,
  output logic [REG_DATA-1:0] reg_write_data,
  output logic                reg_write_control,
  input  logic [REG_ADDR-1:0] reg_1,
  input  logic [REG_ADDR-1:0] reg_2,
  output logic                busy_1,
  output logic                busy_2,
  output logic                stall,
  output logic                ovf
`ifdef WB_FORWARD_EN
  ,
  output logic [REG_DATA-1:0] fwd_1_data,
  output logic [REG_DATA-1:0] fwd_2_data
`endif
);

  localparam int PW = $clog2(WB_DEPTH);

  logic [PW:0]         r_count;
  logic [PW-1:0]       r_rd_ptr;
  logic [PW-1:0]       r_wr_ptr;
  logic                r_ovf;
  logic [REG_ADDR-1:0] r_q_rd   [WB_DEPTH];
  logic [REG_DATA-1:0] r_q_data [WB_DEPTH];

  logic          w_full;
  logic          w_q_nonempty;
  logic          w_alu_acc;
  logic          w_mem_acc;
  logic          w_deq;
  logic          w_enq_alu;
  logic          w_enq_mem;
  logic [1:0]    w_n_enq;
  logic [WB_DEPTH-1:0] w_valid;

  assign w_full       = (r_count == (PW+1)'(WB_DEPTH));
  assign w_q_nonempty = (r_count != '0);
  assign mem_ready    = !w_full && !rst;
  assign stall        = w_full && !rst;
  assign ovf          = r_ovf;

  // rd==0 results are accepted but never become write candidates.
  assign w_alu_acc = alu_valid && !w_full && !rst && (alu_rd != '0);
  assign w_mem_acc = mem_valid && mem_ready && (mem_rd != '0);
  assign w_deq     = w_q_nonempty && !rst;

  // A result goes to the queue unless it is the one taking the direct path;
  // the direct path exists only while the queue is empty, ALU first.
  assign w_enq_alu = w_alu_acc && w_q_nonempty;
  assign w_enq_mem = w_mem_acc && (w_q_nonempty || w_alu_acc);
  assign w_n_enq   = {1'b0, w_enq_alu} + {1'b0, w_enq_mem};

  always_comb begin
    reg_write_control = 1'b0;
    reg_write         = '0;
    reg_write_data    = '0;
    if (rst) begin
      reg_write_control = 1'b0;
    end else if (w_q_nonempty) begin
      reg_write_control = 1'b1;
      reg_write         = r_q_rd[r_rd_ptr];
      reg_write_data    = r_q_data[r_rd_ptr];
    end else if (w_alu_acc) begin
      reg_write_control = 1'b1;
      reg_write         = alu_rd;
      reg_write_data    = alu_data;
    end else if (w_mem_acc) begin
      reg_write_control = 1'b1;
      reg_write         = mem_rd;
      reg_write_data    = mem_data;
    end
  end

  // Hazard scan: w_valid is indexed by age (0 = head). Later entries overwrite
  // the forwarded value so the youngest match wins.
  always_comb begin
    busy_1  = 1'b0;
    busy_2  = 1'b0;
    w_valid = '0;
`ifdef WB_FORWARD_EN
    fwd_1_data = '0;
    fwd_2_data = '0;
`endif
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      w_valid[i] = (i < 32'(r_count)) && !rst;
      if (w_valid[i] && (reg_1 != '0) && (r_q_rd[r_rd_ptr + PW'(i)] == reg_1)) begin
        busy_1 = 1'b1;
`ifdef WB_FORWARD_EN
        fwd_1_data = r_q_data[r_rd_ptr + PW'(i)];
`endif
      end
      if (w_valid[i] && (reg_2 != '0) && (r_q_rd[r_rd_ptr + PW'(i)] == reg_2)) begin
        busy_2 = 1'b1;
`ifdef WB_FORWARD_EN
        fwd_2_data = r_q_data[r_rd_ptr + PW'(i)];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (alu_valid && w_full)
        r_ovf <= 1'b1;
      r_rd_ptr <= r_rd_ptr + PW'(w_deq);
      r_wr_ptr <= r_wr_ptr + PW'(w_n_enq);
      r_count  <= r_count + (PW+1)'(w_n_enq) - (PW+1)'(w_deq);
    end
  end

  // Queue storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_enq_alu) begin
        r_q_rd[r_wr_ptr]   <= alu_rd;
        r_q_data[r_wr_ptr] <= alu_data;
      end else if (w_enq_mem) begin
        r_q_rd[r_wr_ptr]   <= mem_rd;
        r_q_data[r_wr_ptr] <= mem_data;
      end
      if (w_enq_alu && w_enq_mem) begin
        r_q_rd[r_wr_ptr + PW'(1)]   <= mem_rd;
        r_q_data[r_wr_ptr + PW'(1)] <= mem_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Self-checking bench for regfile_writeback_ctrl (default build, WB_DEPTH=4).
// Expected writes are pushed in program order as results are presented and
// popped when the write port fires.
module tb_regfile_writeback_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_rd, mem_rd, reg_1, reg_2;
  logic [31:0] alu_data, mem_data;
  logic        mem_ready, reg_write_control, busy_1, busy_2, stall, ovf;
  logic [4:0]  reg_write;
  logic [31:0] reg_write_data;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  wr_t         sb[$];
  int          m_cnt;
  logic        m_ovf;
  logic [31:0] rf [32];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  regfile_writeback_ctrl #(
    .REG_ADDR(5),
    .REG_DATA(32),
    .WB_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_ready(mem_ready),
    .reg_write(reg_write), .reg_write_data(reg_write_data),
    .reg_write_control(reg_write_control),
    .reg_1(reg_1), .reg_2(reg_2),
    .busy_1(busy_1), .busy_2(busy_2),
    .stall(stall), .ovf(ovf)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock cycle of stimulus; starts just after a posedge.
  task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                     input logic [4:0] r1, input logic [4:0] r2);
    logic e_b1, e_b2, acc_a, acc_m;
    wr_t  w;
    #1;
    rst = 1'b0;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    reg_1 = r1; reg_2 = r2;
    @(negedge clk);
    e_b1 = 1'b0;
    e_b2 = 1'b0;
    for (int i = 0; i < m_cnt; i++) begin
      if (r1 != 0 && sb[i].rd == r1) e_b1 = 1'b1;
      if (r2 != 0 && sb[i].rd == r2) e_b2 = 1'b1;
    end
    check("stall", stall, (m_cnt == DEPTH));
    check("mem_ready", mem_ready, (m_cnt < DEPTH));
    check("busy_1", busy_1, e_b1);
    check("busy_2", busy_2, e_b2);
    check("ovf", ovf, m_ovf);
    acc_a = av && (m_cnt < DEPTH) && (ard != 0);
    acc_m = mv && (m_cnt < DEPTH) && (mrd != 0);
    if (acc_a) sb.push_back('{rd: ard, d: ad});
    if (acc_m) sb.push_back('{rd: mrd, d: md});
    check("wr_ctrl", reg_write_control, (sb.size() > 0));
    if (reg_write_control) rf[reg_write] = reg_write_data;
    if (sb.size() > 0 && reg_write_control) begin
      w = sb.pop_front();
      check("wr_addr", reg_write, w.rd);
      check("wr_data", reg_write_data, w.d);
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
    if (av && m_cnt == DEPTH) m_ovf = 1'b1;
    @(posedge clk);
    m_cnt = sb.size();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h55;
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h66;
    reg_1 = 5'd4; reg_2 = 5'd6;
    @(negedge clk);
    check("rst_wr_ctrl", reg_write_control, 0);
    check("rst_wr_addr", reg_write, 0);
    check("rst_wr_data", reg_write_data, 0);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_stall", stall, 0);
    check("rst_busy_1", busy_1, 0);
    check("rst_busy_2", busy_2, 0);
    @(posedge clk);
    sb.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    reg_1 = 0; reg_2 = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    @(posedge clk);
    do_reset();

    // Direct ALU write, zero latency
    cyc(1, 5, 32'h14, 0, 0, 0, 5, 0);
    check("q_empty_after_direct", m_cnt, 0);

    // ALU and load together: r3 now, r7 next cycle
    cyc(1, 3, 32'hA, 1, 7, 32'hB, 7, 3);
    cyc(0, 0, 0, 0, 0, 0, 7, 3);
    cyc(0, 0, 0, 0, 0, 0, 7, 3);

    // rd==0 discarded
    cyc(1, 0, 32'hFF, 0, 0, 0, 0, 0);
    check("rd0_rf", rf[0], 0);

    // Fill to 4 with concurrent results, then stall/ovf, leaving count=3
    cyc(1, 1, 32'h101, 1, 2, 32'h202, 2, 1);
    cyc(1, 3, 32'h303, 1, 4, 32'h404, 4, 2);
    cyc(1, 5, 32'h505, 1, 6, 32'h606, 6, 5);
    cyc(1, 7, 32'h707, 1, 8, 32'h808, 8, 7);
    check("full_count", m_cnt, DEPTH);
    cyc(1, 9, 32'h909, 1, 10, 32'hA0A, 9, 8);
    check("count_after_stall", m_cnt, 3);
    cyc(0, 0, 0, 0, 0, 0, 9, 10);
    // Reset with queued writes; nothing stale may follow
    do_reset();
    idle(6);

    // Same destination via load then ALU; ALU value must land last
    cyc(1, 1, 32'h11, 1, 9, 32'h900, 9, 1);
    cyc(1, 9, 32'h9A1, 0, 0, 0, 9, 0);
    cyc(0, 0, 0, 0, 0, 0, 9, 0);
    idle(2);
    check("r9_final", rf[9], 32'h9A1);

    // Random traffic with a small register set to provoke hazards and stalls
    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
          ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(DEPTH + 2);
    check("drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
